// File: rtl/sy_ppl_csr_regfile.sv
// rtl/sy_ppl_csr_regfile.sv - machine-mode CSR register file answering CSR-pipe queries and retire writes
// Optional counters mcycle/minstret/cycle/instret are built when SY_CSR_PERF_CNT_EN is defined.
package sy_ppl_csr_pkg;
  localparam int DWTH = 64;

  typedef struct packed {
    logic        csr_query_en;
    logic        rd_en;
    logic [11:0] raddr;
    logic        is_wr;
    logic        is_rd;
  } csr_bus_req_t;

  typedef struct packed {
    logic [DWTH-1:0] rdata;
    logic            excp_en;
    logic            need_flush;
  } csr_bus_rsp_t;

  typedef struct packed {
    logic            wr_en;
    logic [11:0]     waddr;
    logic [DWTH-1:0] wdata;
  } csr_bus_wr_t;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;
endpackage

module sy_ppl_csr_regfile
  import sy_ppl_csr_pkg::*;
#(
  parameter logic [DWTH-1:0] HART_ID   = '0,
  parameter logic [DWTH-1:0] MTVEC_RST = 64'h8000_0000,
  parameter logic [DWTH-1:0] MISA_VAL  = 64'h8000_0000_0014_112D
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  csr_bus_req_t    csr_req_i,
  output csr_bus_rsp_t    csr_rsp_o,
  input  csr_bus_wr_t     csr_wr_i,
  input  logic [1:0]      priv_lvl_i,
  input  logic [1:0]      retire_cnt_i,
  input  logic            trap_en_i,
  input  logic [DWTH-1:0] trap_cause_i,
  input  logic [DWTH-1:0] trap_epc_i,
  input  logic [DWTH-1:0] trap_tval_i,
  input  logic            mret_i,
  output logic [DWTH-1:0] mtvec_o,
  output logic [DWTH-1:0] mepc_o,
  output logic            mstatus_mie_o,
  output logic [DWTH-1:0] mie_o
);

  logic            st_mie_q;
  logic            st_mpie_q;
  logic [DWTH-1:0] mie_q;
  logic [DWTH-1:0] mtvec_q;
  logic [DWTH-1:0] mscratch_q;
  logic [DWTH-1:0] mepc_q;
  logic [DWTH-1:0] mcause_q;
  logic [DWTH-1:0] mtval_q;
  logic [DWTH-1:0] mcycle_val;
  logic [DWTH-1:0] minstret_val;
  logic [DWTH-1:0] mstatus_val;
  csr_bus_rsp_t    rsp_q;

  logic            rd_impl;
  logic [DWTH-1:0] rd_val;
  logic            rd_excp;
  logic            rd_flush;

  logic wr_mstatus;
  logic wr_mie;
  logic wr_mtvec;
  logic wr_mscratch;
  logic wr_mepc;
  logic wr_mcause;
  logic wr_mtval;

  logic unused_is_rd;

  // Only MIE/MPIE are stored; MPP is hardwired to M-mode.
  assign mstatus_val = {{(DWTH-13){1'b0}}, 2'b11, 3'b000, st_mpie_q, 3'b000, st_mie_q, 3'b000};

  assign wr_mstatus  = csr_wr_i.wr_en && (csr_wr_i.waddr == CSR_MSTATUS);
  assign wr_mie      = csr_wr_i.wr_en && (csr_wr_i.waddr == CSR_MIE);
  assign wr_mtvec    = csr_wr_i.wr_en && (csr_wr_i.waddr == CSR_MTVEC);
  assign wr_mscratch = csr_wr_i.wr_en && (csr_wr_i.waddr == CSR_MSCRATCH);
  assign wr_mepc     = csr_wr_i.wr_en && (csr_wr_i.waddr == CSR_MEPC);
  assign wr_mcause   = csr_wr_i.wr_en && (csr_wr_i.waddr == CSR_MCAUSE);
  assign wr_mtval    = csr_wr_i.wr_en && (csr_wr_i.waddr == CSR_MTVAL);

`ifdef SY_CSR_PERF_CNT_EN
  logic [DWTH-1:0] mcycle_q;
  logic [DWTH-1:0] minstret_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (csr_wr_i.wr_en && (csr_wr_i.waddr == CSR_MCYCLE))
        mcycle_q <= csr_wr_i.wdata;
      else
        mcycle_q <= mcycle_q + {{(DWTH-1){1'b0}}, 1'b1};
      if (csr_wr_i.wr_en && (csr_wr_i.waddr == CSR_MINSTRET))
        minstret_q <= csr_wr_i.wdata;
      else
        minstret_q <= minstret_q + {{(DWTH-2){1'b0}}, retire_cnt_i};
    end
  end

  assign mcycle_val   = mcycle_q;
  assign minstret_val = minstret_q;
`else
  logic [1:0] unused_retire_cnt;

  assign mcycle_val        = '0;
  assign minstret_val      = '0;
  assign unused_retire_cnt = retire_cnt_i;
`endif

  assign unused_is_rd = csr_req_i.is_rd;

  // Counter addresses stay decoded in both builds so they never fault on M-mode access.
  always_comb begin
    rd_impl = 1'b1;
    rd_val  = '0;
    case (csr_req_i.raddr)
      CSR_MSTATUS:             rd_val = mstatus_val;
      CSR_MISA:                rd_val = MISA_VAL;
      CSR_MIE:                 rd_val = mie_q;
      CSR_MTVEC:               rd_val = mtvec_q;
      CSR_MSCRATCH:            rd_val = mscratch_q;
      CSR_MEPC:                rd_val = mepc_q;
      CSR_MCAUSE:              rd_val = mcause_q;
      CSR_MTVAL:               rd_val = mtval_q;
      CSR_MCYCLE, CSR_CYCLE:   rd_val = mcycle_val;
      CSR_MINSTRET, CSR_INSTRET: rd_val = minstret_val;
      CSR_MHARTID:             rd_val = HART_ID;
      default:                 rd_impl = 1'b0;
    endcase
  end

  assign rd_excp  = !rd_impl
                  || (csr_req_i.is_wr && (csr_req_i.raddr[11:10] == 2'b11))
                  || (priv_lvl_i < csr_req_i.raddr[9:8]);
  assign rd_flush = csr_req_i.is_wr && !rd_excp
                  && ((csr_req_i.raddr == CSR_MSTATUS) || (csr_req_i.raddr == CSR_MIE));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      rsp_q      <= '0;
    end else begin
      if (csr_req_i.csr_query_en) begin
        rsp_q.rdata      <= (rd_excp || !csr_req_i.rd_en) ? '0 : rd_val;
        rsp_q.excp_en    <= rd_excp;
        rsp_q.need_flush <= rd_flush;
      end else begin
        rsp_q.excp_en    <= 1'b0;
        rsp_q.need_flush <= 1'b0;
      end

      // Trap beats mret beats a software write, field by field.
      if (trap_en_i) begin
        st_mpie_q <= st_mie_q;
        st_mie_q  <= 1'b0;
      end else if (mret_i) begin
        st_mie_q  <= st_mpie_q;
        st_mpie_q <= 1'b1;
      end else if (wr_mstatus) begin
        st_mie_q  <= csr_wr_i.wdata[3];
        st_mpie_q <= csr_wr_i.wdata[7];
      end

      if (trap_en_i) begin
        mepc_q   <= trap_epc_i;
        mcause_q <= trap_cause_i;
        mtval_q  <= trap_tval_i;
      end else begin
        if (wr_mepc)   mepc_q   <= {csr_wr_i.wdata[DWTH-1:1], 1'b0};
        if (wr_mcause) mcause_q <= csr_wr_i.wdata;
        if (wr_mtval)  mtval_q  <= csr_wr_i.wdata;
      end

      if (wr_mie)      mie_q      <= csr_wr_i.wdata;
      if (wr_mtvec)    mtvec_q    <= {csr_wr_i.wdata[DWTH-1:2], 2'b00};
      if (wr_mscratch) mscratch_q <= csr_wr_i.wdata;
    end
  end

  assign csr_rsp_o     = rsp_q;
  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;
  assign mstatus_mie_o = st_mie_q;
  assign mie_o         = mie_q;

endmodule

// File: tb/tb_sy_ppl_csr_regfile.sv
// tb/tb_sy_ppl_csr_regfile.sv - randomized and directed bench for sy_ppl_csr_regfile against a CSR-map model
module tb_sy_ppl_csr_regfile;
  import sy_ppl_csr_pkg::*;

`ifdef SY_CSR_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [63:0] MISA = 64'h8000_0000_0014_112D;

  logic         clk = 1'b0;
  logic         rst;
  csr_bus_req_t req;
  csr_bus_rsp_t rsp;
  csr_bus_wr_t  wr;
  logic [1:0]   priv;
  logic [1:0]   retire;
  logic         trap_en;
  logic [63:0]  cause, epc, tval;
  logic         mret;
  logic [63:0]  mtvec_o, mepc_o, mie_o;
  logic         mstatus_mie_o;

  int nchk = 0;
  int nerr = 0;

  logic [63:0] m_csr [0:4095];
  logic [63:0] e_rdata;
  logic        e_excp, e_flush;

  always #5 clk = ~clk;

  sy_ppl_csr_regfile dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .csr_req_i    (req),
    .csr_rsp_o    (rsp),
    .csr_wr_i     (wr),
    .priv_lvl_i   (priv),
    .retire_cnt_i (retire),
    .trap_en_i    (trap_en),
    .trap_cause_i (cause),
    .trap_epc_i   (epc),
    .trap_tval_i  (tval),
    .mret_i       (mret),
    .mtvec_o      (mtvec_o),
    .mepc_o       (mepc_o),
    .mstatus_mie_o(mstatus_mie_o),
    .mie_o        (mie_o)
  );

  function automatic bit m_impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
      12'hB00, 12'hB02, 12'hC00, 12'hC02, 12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a);
    case (a)
      12'hB00, 12'hC00: return PERF ? m_csr[12'hB00] : 64'd0;
      12'hB02, 12'hC02: return PERF ? m_csr[12'hB02] : 64'd0;
      default:          return m_csr[a];
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4096; i++) m_csr[i] = 64'd0;
    m_csr[12'h300] = 64'h1800;
    m_csr[12'h301] = MISA;
    m_csr[12'h305] = 64'h8000_0000;
    e_rdata = 64'd0;
    e_excp  = 1'b0;
    e_flush = 1'b0;
  endtask

  // One clock edge of the architectural CSR map, evaluated from the inputs held this cycle.
  task automatic model_step();
    logic [11:0] a;
    logic [63:0] old_ms;
    bit          ex, wc, wi;
    if (rst) begin
      model_reset();
      return;
    end
    if (req.csr_query_en) begin
      a  = req.raddr;
      ex = !m_impl(a) || (req.is_wr && a[11:10] == 2'b11) || (priv < a[9:8]);
      e_excp  = ex;
      e_flush = req.is_wr && !ex && (a == 12'h300 || a == 12'h304);
      e_rdata = (ex || !req.rd_en) ? 64'd0 : m_read(a);
    end else begin
      e_excp  = 1'b0;
      e_flush = 1'b0;
    end
    old_ms = m_csr[12'h300];
    wc = 0;
    wi = 0;
    if (wr.wr_en) begin
      case (wr.waddr)
        12'h300: m_csr[12'h300] = (wr.wdata & 64'h88) | 64'h1800;
        12'h304, 12'h340, 12'h342, 12'h343: m_csr[wr.waddr] = wr.wdata;
        12'h305: m_csr[12'h305] = wr.wdata & ~64'h3;
        12'h341: m_csr[12'h341] = wr.wdata & ~64'h1;
        12'hB00: if (PERF) begin m_csr[12'hB00] = wr.wdata; wc = 1; end
        12'hB02: if (PERF) begin m_csr[12'hB02] = wr.wdata; wi = 1; end
        default: ;
      endcase
    end
    if (PERF && !wc) m_csr[12'hB00] = m_csr[12'hB00] + 64'd1;
    if (PERF && !wi) m_csr[12'hB02] = m_csr[12'hB02] + 64'(retire);
    if (mret) m_csr[12'h300] = 64'h1880 | (old_ms[7] ? 64'h8 : 64'h0);
    if (trap_en) begin
      m_csr[12'h300] = 64'h1800 | (old_ms[3] ? 64'h80 : 64'h0);
      m_csr[12'h341] = epc;
      m_csr[12'h342] = cause;
      m_csr[12'h343] = tval;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    req = '0; wr = '0; priv = 2'd3; retire = 2'd0;
    trap_en = 1'b0; cause = '0; epc = '0; tval = '0; mret = 1'b0;
  endtask

  task automatic set_q(input logic [11:0] a, input logic rd, input logic w);
    req = '0;
    req.csr_query_en = 1'b1;
    req.rd_en = rd;
    req.raddr = a;
    req.is_wr = w;
    req.is_rd = rd;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    set_q(12'h305, 1'b1, 1'b0);
    wr = '{wr_en: 1'b1, waddr: 12'h305, wdata: 64'h1234};
    trap_en = 1'b1; epc = 64'h44;
    step(); step();
    rst = 1'b0;
    idle();
    nchk++; if (rsp !== '0) begin nerr++; $display("FAIL reset_rsp got=%h exp=0", rsp); end
    nchk++; if (mtvec_o !== 64'h8000_0000) begin nerr++; $display("FAIL reset_mtvec got=%h exp=80000000", mtvec_o); end
    nchk++; if (mepc_o !== 64'd0 || mie_o !== 64'd0 || mstatus_mie_o !== 1'b0)
      begin nerr++; $display("FAIL reset_outs mepc=%h mie=%h mstatus_mie=%b exp 0/0/0", mepc_o, mie_o, mstatus_mie_o); end
  endtask

  task automatic test_query();
    idle(); set_q(12'h305, 1'b1, 1'b0); step();
    nchk++; if (rsp.rdata !== 64'h8000_0000 || rsp.excp_en !== 1'b0 || rsp.need_flush !== 1'b0)
      begin nerr++; $display("FAIL query_mtvec got=%h/%b/%b exp 80000000/0/0", rsp.rdata, rsp.excp_en, rsp.need_flush); end
    idle(); step();
    nchk++; if (rsp.rdata !== 64'h8000_0000 || rsp.excp_en !== 1'b0 || rsp.need_flush !== 1'b0)
      begin nerr++; $display("FAIL query_hold got=%h/%b/%b exp 80000000/0/0", rsp.rdata, rsp.excp_en, rsp.need_flush); end
    set_q(12'h7C0, 1'b1, 1'b0); step();
    nchk++; if (rsp.excp_en !== 1'b1 || rsp.rdata !== 64'd0)
      begin nerr++; $display("FAIL query_unimpl got=%h/%b exp 0/1", rsp.rdata, rsp.excp_en); end
    set_q(12'hF14, 1'b1, 1'b1); step();
    nchk++; if (rsp.excp_en !== 1'b1) begin nerr++; $display("FAIL query_ro_write excp=%b exp 1", rsp.excp_en); end
    priv = 2'd0; set_q(12'h340, 1'b1, 1'b0); step();
    nchk++; if (rsp.excp_en !== 1'b1 || rsp.rdata !== 64'd0)
      begin nerr++; $display("FAIL query_priv got=%h/%b exp 0/1", rsp.rdata, rsp.excp_en); end
    priv = 2'd3; set_q(12'h300, 1'b1, 1'b1); step();
    nchk++; if (rsp.need_flush !== 1'b1 || rsp.excp_en !== 1'b0 || rsp.rdata !== 64'h1800)
      begin nerr++; $display("FAIL query_flush got=%h/%b/%b exp 1800/0/1", rsp.rdata, rsp.excp_en, rsp.need_flush); end
    set_q(12'h301, 1'b1, 1'b0); step();
    nchk++; if (rsp.rdata !== MISA) begin nerr++; $display("FAIL query_misa got=%h exp=%h", rsp.rdata, MISA); end
    set_q(12'h305, 1'b0, 1'b0); step();
    nchk++; if (rsp.rdata !== 64'd0 || rsp.excp_en !== 1'b0)
      begin nerr++; $display("FAIL query_no_rd got=%h/%b exp 0/0", rsp.rdata, rsp.excp_en); end
    idle();
  endtask

  task automatic test_mstatus_write();
    idle(); wr = '{wr_en: 1'b1, waddr: 12'h300, wdata: 64'hFFFF}; step();
    idle();
    nchk++; if (mstatus_mie_o !== 1'b1) begin nerr++; $display("FAIL mstatus_mie got=%b exp=1", mstatus_mie_o); end
    set_q(12'h300, 1'b1, 1'b0); step();
    nchk++; if (rsp.rdata !== 64'h1888) begin nerr++; $display("FAIL mstatus_read got=%h exp=1888", rsp.rdata); end
    idle();
  endtask

  task automatic test_trap_mret();
    idle();
    wr = '{wr_en: 1'b1, waddr: 12'h341, wdata: 64'h100};
    trap_en = 1'b1; epc = 64'h200; cause = 64'h7; tval = 64'h55;
    step(); idle();
    nchk++; if (mepc_o !== 64'h200 || mstatus_mie_o !== 1'b0)
      begin nerr++; $display("FAIL trap_outs mepc=%h mie=%b exp 200/0", mepc_o, mstatus_mie_o); end
    set_q(12'h300, 1'b1, 1'b0); step();
    nchk++; if (rsp.rdata !== 64'h1880) begin nerr++; $display("FAIL trap_mstatus got=%h exp=1880", rsp.rdata); end
    set_q(12'h342, 1'b1, 1'b0); step();
    nchk++; if (rsp.rdata !== 64'h7) begin nerr++; $display("FAIL trap_mcause got=%h exp=7", rsp.rdata); end
    idle(); mret = 1'b1; step(); idle();
    nchk++; if (mstatus_mie_o !== 1'b1) begin nerr++; $display("FAIL mret_mie got=%b exp=1", mstatus_mie_o); end
    set_q(12'h300, 1'b1, 1'b0); step();
    nchk++; if (rsp.rdata !== 64'h1888) begin nerr++; $display("FAIL mret_mstatus got=%h exp=1888", rsp.rdata); end
    idle(); wr = '{wr_en: 1'b1, waddr: 12'h341, wdata: 64'h103}; step();
    nchk++; if (mepc_o !== 64'h102) begin nerr++; $display("FAIL mepc_mask got=%h exp=102", mepc_o); end
    wr = '{wr_en: 1'b1, waddr: 12'h305, wdata: 64'h8000_0007}; step();
    nchk++; if (mtvec_o !== 64'h8000_0004) begin nerr++; $display("FAIL mtvec_mask got=%h exp=80000004", mtvec_o); end
    wr = '{wr_en: 1'b1, waddr: 12'h304, wdata: 64'hA0A}; step();
    nchk++; if (mie_o !== 64'hA0A) begin nerr++; $display("FAIL mie_write got=%h exp=a0a", mie_o); end
    idle();
  endtask

  task automatic test_same_cycle_rw();
    idle(); wr = '{wr_en: 1'b1, waddr: 12'h340, wdata: 64'h33}; step();
    wr = '{wr_en: 1'b1, waddr: 12'h340, wdata: 64'hA5}; set_q(12'h340, 1'b1, 1'b0); step();
    wr = '0;
    nchk++; if (rsp.rdata !== 64'h33) begin nerr++; $display("FAIL rw_old got=%h exp=33", rsp.rdata); end
    step();
    nchk++; if (rsp.rdata !== 64'hA5) begin nerr++; $display("FAIL rw_new got=%h exp=a5", rsp.rdata); end
    idle();
  endtask

  task automatic test_counters();
    idle(); rst = 1'b1; step(); rst = 1'b0;
    retire = 2'd2;
    repeat (10) step();
    retire = 2'd0;
    set_q(12'hB00, 1'b1, 1'b0); step();
    nchk++; if (rsp.rdata !== (PERF ? 64'd10 : 64'd0) || rsp.excp_en !== 1'b0)
      begin nerr++; $display("FAIL cnt_mcycle got=%h/%b exp=%h/0", rsp.rdata, rsp.excp_en, PERF ? 64'd10 : 64'd0); end
    set_q(12'hB02, 1'b1, 1'b0); step();
    nchk++; if (rsp.rdata !== (PERF ? 64'd20 : 64'd0))
      begin nerr++; $display("FAIL cnt_minstret got=%h exp=%h", rsp.rdata, PERF ? 64'd20 : 64'd0); end
    idle(); wr = '{wr_en: 1'b1, waddr: 12'hB00, wdata: 64'hFFFF_FFFF_FFFF_FFFF}; step();
    idle(); set_q(12'hB00, 1'b1, 1'b0); step();
    nchk++; if (rsp.rdata !== (PERF ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0))
      begin nerr++; $display("FAIL cnt_written got=%h", rsp.rdata); end
    set_q(12'hC00, 1'b1, 1'b0); step();
    nchk++; if (rsp.rdata !== 64'd0) begin nerr++; $display("FAIL cnt_wrap got=%h exp=0", rsp.rdata); end
    set_q(12'hC00, 1'b1, 1'b1); step();
    nchk++; if (rsp.excp_en !== 1'b1) begin nerr++; $display("FAIL cnt_alias_ro excp=%b exp=1", rsp.excp_en); end
    idle();
  endtask

  task automatic test_reset_midop();
    idle(); wr = '{wr_en: 1'b1, waddr: 12'h305, wdata: 64'h4000}; step();
    set_q(12'h305, 1'b1, 1'b0); wr = '0; step();
    nchk++; if (rsp.rdata !== 64'h4000) begin nerr++; $display("FAIL midop_pre got=%h exp=4000", rsp.rdata); end
    rst = 1'b1;
    wr = '{wr_en: 1'b1, waddr: 12'h341, wdata: 64'h88};
    trap_en = 1'b1; epc = 64'h300;
    step();
    rst = 1'b0; idle();
    nchk++; if (rsp !== '0) begin nerr++; $display("FAIL midop_rsp got=%h exp=0", rsp); end
    nchk++; if (mtvec_o !== 64'h8000_0000 || mepc_o !== 64'd0)
      begin nerr++; $display("FAIL midop_regs mtvec=%h mepc=%h exp 80000000/0", mtvec_o, mepc_o); end
  endtask

  task automatic test_random();
    logic [11:0] addrs [16];
    addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
              12'hB00, 12'hB02, 12'hC00, 12'hC02, 12'hF14, 12'h7C0, 12'h3A0, 12'hF11};
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      req = '0;
      if ($urandom_range(0, 3) != 0)
        set_q(addrs[$urandom_range(0, 15)], 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
      wr.wr_en = 1'($urandom_range(0, 1));
      wr.waddr = addrs[$urandom_range(0, 15)];
      wr.wdata = {$urandom, $urandom};
      priv     = 2'($urandom_range(0, 3));
      retire   = 2'($urandom_range(0, 2));
      trap_en  = ($urandom_range(0, 15) == 0);
      mret     = ($urandom_range(0, 11) == 0);
      cause    = {$urandom, $urandom};
      epc      = {$urandom, $urandom};
      tval     = {$urandom, $urandom};
      step();
      nchk++; if (rsp.rdata !== e_rdata || rsp.excp_en !== e_excp || rsp.need_flush !== e_flush)
        begin nerr++; $display("FAIL rand_rsp cyc=%0d got=%h/%b/%b exp=%h/%b/%b", c, rsp.rdata, rsp.excp_en, rsp.need_flush, e_rdata, e_excp, e_flush); end
      nchk++; if (mtvec_o !== m_csr[12'h305] || mepc_o !== m_csr[12'h341] || mie_o !== m_csr[12'h304] || mstatus_mie_o !== m_csr[12'h300][3])
        begin nerr++; $display("FAIL rand_outs cyc=%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b", c, mtvec_o, mepc_o, mie_o, mstatus_mie_o,
                               m_csr[12'h305], m_csr[12'h341], m_csr[12'h304], m_csr[12'h300][3]); end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    test_reset();
    test_query();
    test_mstatus_write();
    test_trap_mret();
    test_same_cycle_rw();
    test_counters();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
